// File: rtl/simd_shifter_pkg.sv
// Shared types and helpers for the SIMD shifter family: lane-union word,
// lane-size and operation encodings, per-lane shift amount.
package simd_shifter_pkg;

    localparam int SHIFT_STAGES_MAX = 6;

    typedef union packed {
        logic [63:0]      w64;
        logic [1:0][31:0] w32;
        logic [3:0][15:0] w16;
        logic [7:0][7:0]  w8;
    } word_t;

    typedef enum logic [2:0] {
        MODE_8B = 3'd0,
        MODE_4B = 3'd1,
        MODE_2B = 3'd2,
        MODE_1B = 3'd3
    } mode_t;

    typedef enum logic [2:0] {
        OP_SLL = 3'd0,
        OP_SRL = 3'd1,
        OP_SLA = 3'd2,
        OP_SRA = 3'd3
    } op_t;

    typedef logic [5:0] shift_t;

    function automatic logic mode_valid(input mode_t m);
        return (m == MODE_8B) || (m == MODE_4B) || (m == MODE_2B) || (m == MODE_1B);
    endfunction

    function automatic logic op_valid(input op_t o);
        return (o == OP_SLL) || (o == OP_SRL) || (o == OP_SLA) || (o == OP_SRA);
    endfunction

    // Stages needed = log2(lane width); unknown modes fall back to the 64b lane.
    function automatic logic [2:0] stages_for(input mode_t m);
        case (m)
            MODE_4B: return 3'd5;
            MODE_2B: return 3'd4;
            MODE_1B: return 3'd3;
            default: return 3'(SHIFT_STAGES_MAX);
        endcase
    endfunction

    function automatic logic [3:0] lanes_for(input mode_t m);
        case (m)
            MODE_4B: return 4'd2;
            MODE_2B: return 4'd4;
            MODE_1B: return 4'd8;
            default: return 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/simd_shifter_stage.sv
// One log-shifter stage: every enabled lane is shifted by 2^k with lane-local
// fill; disabled lanes, unknown ops and unknown modes pass through.
module simd_shifter_stage
    import simd_shifter_pkg::*;
(
    input  word_t      word,
    input  mode_t      mode,
    input  op_t        op,
    input  logic [2:0] k,
    input  logic [7:0] en,
    output word_t      result
);

    logic [5:0] amt;
    logic       left;
    logic       arith;

    assign amt   = 6'd1 << k;
    assign left  = (op == OP_SLL) || (op == OP_SLA);
    assign arith = (op == OP_SRA);

    // Lane sits in the low w bits of x; sign-extend for SRA, shift, re-mask.
    function automatic logic [63:0] lane_shift(input logic [63:0] x, input int w,
                                               input logic [5:0] a, input logic l,
                                               input logic ar);
        logic [63:0] mask;
        logic [63:0] ext;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        ext  = x & mask;
        if (ar && |(x & (mask & ~(mask >> 1))))
            ext = ext | ~mask;
        if (l)
            return (ext << a) & mask;
        if (ar)
            return 64'($signed(ext) >>> a) & mask;
        return ext >> a;
    endfunction

    always_comb begin
        // NOTE: default assignment first so no path leaves result unassigned (no latch).
        result = word;
        if (op_valid(op)) begin
            case (mode)
                MODE_8B:
                    if (en[0]) result.w64 = lane_shift(word.w64, 64, amt, left, arith);
                MODE_4B:
                    for (int i = 0; i < 2; i++)
                        if (en[i]) result.w32[i] = 32'(lane_shift(64'(word.w32[i]), 32, amt, left, arith));
                MODE_2B:
                    for (int i = 0; i < 4; i++)
                        if (en[i]) result.w16[i] = 16'(lane_shift(64'(word.w16[i]), 16, amt, left, arith));
                MODE_1B:
                    for (int i = 0; i < 8; i++)
                        if (en[i]) result.w8[i] = 8'(lane_shift(64'(word.w8[i]), 8, amt, left, arith));
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/simd_shifter_iter.sv
// Iterative SIMD shifter: one log-shift stage per cycle, lane count chosen by
// mode, saturating lanes whose amount exceeds the lane width.
module simd_shifter_iter
    import simd_shifter_pkg::*;
#(
    parameter int N_STAGES_MAX = SHIFT_STAGES_MAX
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  word_t        in,
    input  mode_t        mode,
    input  op_t          op,
    input  shift_t [7:0] shift,
    output logic         out_vld,
    input  logic         out_rdy,
    output word_t        out
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state;
    logic [2:0]   k_q;
    logic [2:0]   n_q;
    word_t        data_q;
    mode_t        mode_q;
    op_t          op_q;
    shift_t [7:0] amt_q;
    logic [7:0]   sat_q;

    logic       accept;
    logic [2:0] n_in;
    logic [3:0] lanes_in;
    logic [7:0] sat_in;
    logic [7:0] en;
    word_t      stage_res;
    word_t      fill;

    assign in_rdy  = (state == IDLE);
    assign out_vld = (state == DONE);
    assign accept  = in_vld && in_rdy;

    // A lane saturates when its amount has any bit at or above the stage count.
    always_comb begin
        n_in     = mode_valid(mode) ? stages_for(mode) : 3'(N_STAGES_MAX);
        lanes_in = lanes_for(mode);
        sat_in   = '0;
        if (mode_valid(mode) && op_valid(op))
            for (int i = 0; i < 8; i++)
                if (4'(i) < lanes_in && (shift[i] >> n_in) != 6'd0)
                    sat_in[i] = 1'b1;
    end

    always_comb begin
        en = '0;
        for (int i = 0; i < 8; i++)
            en[i] = amt_q[i][k_q] & ~sat_q[i];
    end

    simd_shifter_stage u_stage (
        .word   (data_q),
        .mode   (mode_q),
        .op     (op_q),
        .k      (k_q),
        .en     (en),
        .result (stage_res)
    );

    // Saturated lanes were never shifted, so their MSB is still the original sign.
    always_comb begin
        fill = stage_res;
        case (mode_q)
            MODE_4B:
                for (int i = 0; i < 2; i++)
                    if (sat_q[i]) fill.w32[i] = (op_q == OP_SRA) ? {32{stage_res.w32[i][31]}} : '0;
            MODE_2B:
                for (int i = 0; i < 4; i++)
                    if (sat_q[i]) fill.w16[i] = (op_q == OP_SRA) ? {16{stage_res.w16[i][15]}} : '0;
            MODE_1B:
                for (int i = 0; i < 8; i++)
                    if (sat_q[i]) fill.w8[i] = (op_q == OP_SRA) ? {8{stage_res.w8[i][7]}} : '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples pre-edge values.
        if (rst) begin
            state <= IDLE;
            k_q   <= '0;
            out   <= '0;
        end else begin
            case (state)
                IDLE:
                    if (accept) begin
                        state <= BUSY;
                        k_q   <= '0;
                    end
                BUSY:
                    if (k_q == n_q - 3'd1) begin
                        state <= DONE;
                        out   <= fill;
                    end else begin
                        k_q <= k_q + 3'd1;
                    end
                DONE:
                    if (out_rdy) begin
                        state <= IDLE;
                        k_q   <= '0;
                    end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: payload registers carry no reset; control state alone decides validity.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_q <= in;
            mode_q <= mode;
            op_q   <= op;
            amt_q  <= shift;
            sat_q  <= sat_in;
            n_q    <= n_in;
        end else if (state == BUSY) begin
            data_q <= stage_res;
        end
    end

endmodule

// File: tb/tb_simd_shifter_iter.sv
// Directed bench for simd_shifter_iter: hand-computed vectors per mode/op,
// saturation, hold under backpressure, and reset abort.
module tb_simd_shifter_iter;
    import simd_shifter_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_vld;
    logic         in_rdy;
    word_t        in_w;
    mode_t        mode;
    op_t          op;
    shift_t [7:0] shift;
    logic         out_vld;
    logic         out_rdy;
    word_t        out_w;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    simd_shifter_iter #(.N_STAGES_MAX(6)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .in      (in_w),
        .mode    (mode),
        .op      (op),
        .shift   (shift),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out     (out_w)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a request, let it be accepted, then scramble the inputs.
    task automatic send(input logic [63:0] din, input mode_t m, input op_t o, input shift_t [7:0] sh);
        @(negedge clk);
        check("in_rdy_before_req", 64'(in_rdy), 64'd1);
        in_w   = din;
        mode   = m;
        op     = o;
        shift  = sh;
        in_vld = 1'b1;
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        in_w   = ~din;
        mode   = (m == MODE_1B) ? MODE_8B : MODE_1B;
        op     = (o == OP_SRA) ? OP_SLL : OP_SRA;
        shift  = '1;
    endtask

    task automatic wait_vld(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_vld && lat < 20);
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        out_rdy = 1'b0;
        check({tag, "_in_rdy_after"}, 64'(in_rdy), 64'd1);
        check({tag, "_vld_after"}, 64'(out_vld), 64'd0);
    endtask

    task automatic run(input string tag, input logic [63:0] din, input mode_t m, input op_t o,
                       input shift_t [7:0] sh, input logic [63:0] exp, input int exp_lat);
        int lat;
        send(din, m, o, sh);
        wait_vld(lat);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_out"}, out_w, exp);
        release_out(tag);
    endtask

    initial begin
        int  lat;
        logic seen;

        rst     = 1'b1;
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        in_w    = '0;
        mode    = MODE_8B;
        op      = OP_SLL;
        shift   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_rdy", 64'(in_rdy), 64'd1);
        check("rst_out_vld", 64'(out_vld), 64'd0);
        check("rst_out", out_w, 64'h0);

        run("sll64_63", 64'h1, MODE_8B, OP_SLL,
            {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd63},
            64'h8000_0000_0000_0000, 6);
        run("sra8_3", 64'h8080_8080_7F7F_7F7F, MODE_1B, OP_SRA,
            {8{6'd3}}, 64'hF0F0_F0F0_0F0F_0F0F, 3);
        run("srl16_mix", 64'hFFFF_FFFF_FFFF_FFFF, MODE_2B, OP_SRL,
            {6'd0, 6'd0, 6'd0, 6'd0, 6'd16, 6'd15, 6'd1, 6'd0},
            64'h0000_0001_7FFF_FFFF, 4);
        run("sra32_sat", 64'h8000_0000_0000_0001, MODE_4B, OP_SRA,
            {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd40, 6'd0},
            64'hFFFF_FFFF_0000_0001, 5);
        run("sll8_lanes", 64'h0123_4567_89AB_CDEF, MODE_1B, OP_SLL,
            {6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7},
            64'h0146_1438_9060_4080, 3);
        run("sla16", 64'h8001_4000_00FF_1234, MODE_2B, OP_SLA,
            {6'd0, 6'd0, 6'd0, 6'd0, 6'd1, 6'd2, 6'd8, 6'd4},
            64'h0002_0000_FF00_2340, 4);
        run("sra64_4", 64'h8000_0000_0000_0000, MODE_8B, OP_SRA,
            {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd4},
            64'hF800_0000_0000_0000, 6);
        run("srl64_63", 64'h8000_0000_0000_0000, MODE_8B, OP_SRL,
            {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd63},
            64'h0000_0000_0000_0001, 6);
        run("srl8_sat", 64'hFFFF_FFFF_FFFF_FFFF, MODE_1B, OP_SRL,
            {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd8},
            64'hFFFF_FFFF_FFFF_FF00, 3);
        run("sra8_sat_sign", 64'h807F_0000_0000_0000, MODE_1B, OP_SRA,
            {6'd9, 6'd9, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0},
            64'hFF00_0000_0000_0000, 3);
        run("sll32_sat", 64'h1234_5678_0000_0003, MODE_4B, OP_SLL,
            {6'd0, 6'd0, 6'd63, 6'd0, 6'd0, 6'd0, 6'd32, 6'd31},
            64'h0000_0000_8000_0000, 5);
        run("sra32_zero", 64'hDEAD_BEEF_CAFE_F00D, MODE_4B, OP_SRA,
            '0, 64'hDEAD_BEEF_CAFE_F00D, 5);
        run("bad_op", 64'h0123_4567_89AB_CDEF, MODE_8B, op_t'(3'd6),
            {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd5},
            64'h0123_4567_89AB_CDEF, 6);
        run("bad_mode", 64'hFEDC_BA98_7654_3210, mode_t'(3'd7), OP_SLL,
            {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd5},
            64'hFEDC_BA98_7654_3210, 6);

        // Hold under backpressure while a second request waits on in_vld.
        send(64'h1, MODE_8B, OP_SLL, {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd63});
        wait_vld(lat);
        check("hold_lat", 64'(lat), 64'd6);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_w   = 64'hFFFF_FFFF_FFFF_FFFF;
            mode   = MODE_1B;
            op     = OP_SRL;
            shift  = {8{6'd1}};
            in_vld = 1'b1;
            @(posedge clk);
            #1;
            check("hold_out", out_w, 64'h8000_0000_0000_0000);
            check("hold_in_rdy", 64'(in_rdy), 64'd0);
            check("hold_out_vld", 64'(out_vld), 64'd1);
        end
        @(negedge clk);
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        out_rdy = 1'b0;
        check("hs_no_accept", 64'(in_rdy), 64'd1);
        check("hs_vld_low", 64'(out_vld), 64'd0);
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        check("second_accepted", 64'(in_rdy), 64'd0);
        wait_vld(lat);
        check("second_lat", 64'(lat), 64'd3);
        check("second_out", out_w, 64'h7F7F_7F7F_7F7F_7F7F);
        release_out("second");

        // Reset during BUSY aborts the operation.
        send(64'h1234, MODE_8B, OP_SLL, {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd4});
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_in_rdy", 64'(in_rdy), 64'd1);
        check("abort_out_vld", 64'(out_vld), 64'd0);
        check("abort_out", out_w, 64'h0);
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_vld) seen = 1'b1;
        end
        check("abort_no_vld", 64'(seen), 64'd0);
        run("after_abort", 64'h1234, MODE_8B, OP_SLL,
            {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd4},
            64'h0000_0000_0001_2340, 6);

        // Reset wins over a simultaneous valid request.
        @(negedge clk);
        in_w   = 64'h55;
        mode   = MODE_8B;
        op     = OP_SLL;
        shift  = '0;
        in_vld = 1'b1;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        in_vld = 1'b0;
        check("rst_dom_in_rdy", 64'(in_rdy), 64'd1);
        check("rst_dom_out_vld", 64'(out_vld), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/simd_shifter_iter.md
SIMD_SHIFTER_ITER -- requirements
Module: simd_shifter_iter

Interface
REQ-001 The block SHALL have parameter N_STAGES_MAX, default 6, meaning the number of log-shift stages for the widest (64b) lane.
REQ-002 The block SHALL have port clk, input, 1, the single clock.
REQ-003 The block SHALL have port rst, input, 1, the reset: synchronous, active-high.
REQ-004 The block SHALL have port in_vld, input, 1, which marks the request as valid.
REQ-005 The block SHALL have port in_rdy, output, 1, which shows the block can accept a request.
REQ-006 The block SHALL have port in, input, word_t (64), the operand.
REQ-007 The block SHALL have port mode, input, mode_t, the lane size: MODE_8B = 1x64, MODE_4B = 2x32, MODE_2B = 4x16, MODE_1B = 8x8.
REQ-008 The block SHALL have port op, input, op_t, with values OP_SLL, OP_SRL, OP_SLA and OP_SRA.
REQ-009 The block SHALL have port shift, input, shift_t [7:0] (6b each), the per-lane shift amount; lane i uses shift[i].
REQ-010 The block SHALL have port out_vld, output, 1, which marks the result as valid.
REQ-011 The block SHALL have port out_rdy, input, 1, the consumer accept signal.
REQ-012 The block SHALL have port out, output, word_t, the result.

Function
REQ-013 A request SHALL be accepted on a clk edge where in_vld && in_rdy; in, mode, op and shift are registered on that edge.
REQ-014 in_rdy SHALL be 1 only in state IDLE; there is no overlap, so the next request is accepted only after the result is consumed.
REQ-015 The FSM SHALL have the states IDLE, BUSY and DONE.
- IDLE -> BUSY on accept.
- BUSY -> DONE after N stage edges.
- DONE -> IDLE on out_rdy.
REQ-016 N SHALL be log2(lane width): 6 for 8B, 5 for 4B, 4 for 2B, 3 for 1B; the stage counter runs 0..N-1.
REQ-017 In BUSY, stage k SHALL shift each lane by 2^k when bit k of that lane's amount is set, and SHALL never carry bits across lane boundaries.
REQ-018 Latency: with accept in cycle 0, out_vld SHALL first be high in cycle N+1.
REQ-019 out_vld SHALL equal (state == DONE), and out SHALL hold stable while out_vld && !out_rdy.
REQ-020 Left shifts: OP_SLL and OP_SLA SHALL be identical, with zero fill from the lane LSB.
REQ-021 Right shifts: OP_SRL SHALL zero-fill from the lane MSB, and OP_SRA SHALL fill with the lane's original MSB.
REQ-022 If any amount bit at position >= N is set, that lane's result SHALL saturate: all zeros for SLL/SLA/SRL, all copies of the sign bit for SRA.
REQ-023 The saturation flag SHALL be computed per lane at accept.
REQ-024 Amount 0 SHALL return the lane unchanged.
REQ-025 The mode, op and shift inputs SHALL be ignored outside the accept edge; input changes during BUSY/DONE SHALL have no effect.
REQ-026 Simultaneous out_rdy in DONE and in_vld SHALL NOT accept a new request in that cycle, because in_rdy is 0.
REQ-027 An invalid or unused enum value SHALL pass the operand through unchanged after N cycles for the registered mode; an invalid mode uses N = 6.

Reset
REQ-028 On a clk edge with rst = 1, the state SHALL go to IDLE and the stage counter to 0; in_rdy = 1, out_vld = 0 and out = 64'h0 from the next cycle.
REQ-029 A reset asserted during BUSY or DONE SHALL abort the operation with no output produced, and the result SHALL be discarded.
REQ-030 rst SHALL dominate in_vld on the same edge.

Structure
REQ-031 word_t (union of w64, w32[2], w16[4] and w8[8]), mode_t, op_t and shift_t SHALL live in the shared package simd_shifter_pkg; this block adds no new package types.
REQ-032 The package SHALL also hold the constant SHIFT_STAGES_MAX = 6.
REQ-033 There SHALL be one combinational sub-module, simd_shifter_stage, with inputs word, mode, op, stage index k and per-lane enable bits; it performs a lane-masked shift by 2^k.
REQ-034 The top level SHALL hold the FSM, the counter, the operand/amount/op/mode registers and the saturation flags.

Verification
REQ-035 Test: MODE_8B, OP_SLL, in = 64'h1, shift[0] = 63 -> out = 64'h8000_0000_0000_0000, out_vld in cycle 7.
REQ-036 Test: MODE_1B, OP_SRA, in = 64'h80808080_7F7F7F7F, shift[*] = 3 -> out = 64'hF0F0F0F0_0F0F0F0F, out_vld in cycle 4.
REQ-037 Test: MODE_2B, OP_SRL, in = 64'hFFFF_FFFF_FFFF_FFFF, shift = {…,16,15,1,0} (lanes 3..0 = 16,15,1,0) -> lanes = 0000, 0001, 7FFF, FFFF (saturate on 16).
REQ-038 Test: MODE_4B, OP_SRA, in = 64'h8000_0000_0000_0001, shift[1] = 40 (saturates), shift[0] = 0 -> out = 64'hFFFF_FFFF_0000_0001.
REQ-039 Test: result held with out_rdy = 0 for 5 cycles -> out stable, in_rdy = 0 throughout; a second in_vld is accepted only after the out_rdy handshake.
REQ-040 Test: rst pulsed in cycle 2 of a MODE_8B op -> out_vld never rises, in_rdy = 1 next cycle, and a fresh request completes correctly.
